// File: rtl/cmd_pad_sequencer_if.sv
// cmd_pad_sequencer_if: command, status and CMD-pad signal bundle around the pad sequencer
interface cmd_pad_sequencer_if #(
  parameter int CMD_BITS = 48,
  parameter int RESP_BITS = 48
);
  logic strobe_in;
  logic expect_resp;
  logic [CMD_BITS-1:0] cmd_in;
  logic pad_output_input;
  logic pad_enable;
  logic pad_data_in;
  logic pad_data_out;
  logic busy;
  logic done;
  logic timeout_err;
  logic end_err;
  logic [RESP_BITS-1:0] resp_out;
  modport slave (
    input strobe_in, expect_resp, cmd_in, pad_data_out,
    output pad_output_input, pad_enable, pad_data_in, busy, done, timeout_err, end_err, resp_out
  );
  modport master (
    output strobe_in, expect_resp, cmd_in, pad_data_out,
    input pad_output_input, pad_enable, pad_data_in, busy, done, timeout_err, end_err, resp_out
  );
endinterface

// File: rtl/cmd_pad_sequencer.sv
// cmd_pad_sequencer: serializes a CMD frame MSB first onto the SD pad, turns the pad around and captures the response
module cmd_pad_sequencer #(
  parameter int CMD_BITS = 48,
  parameter int RESP_BITS = 48,
  parameter int TIMEOUT = 64,
  parameter int TO_W = 7
) (
  input logic sd_clock,
  input logic reset,
  cmd_pad_sequencer_if.slave bus
);
  localparam int CW = $clog2((CMD_BITS > RESP_BITS) ? CMD_BITS : RESP_BITS);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, RECEIVE, DONE} state_t;
  state_t state;
  logic [CMD_BITS-1:0] cmd_sh;
  logic [RESP_BITS-2:0] resp_sh;
  logic [CW-1:0] cnt;
  logic [TO_W-1:0] to_cnt;
  logic exp_r;
  assign bus.pad_enable = 1'b1;
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state <= IDLE;
      cmd_sh <= '0;
      resp_sh <= '0;
      cnt <= '0;
      to_cnt <= '0;
      exp_r <= 1'b0;
      bus.pad_output_input <= 1'b1;
      bus.pad_data_in <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.end_err <= 1'b0;
      bus.resp_out <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.strobe_in) begin
          state <= SEND;
          cmd_sh <= {bus.cmd_in[CMD_BITS-2:0], 1'b1};
          exp_r <= bus.expect_resp;
          cnt <= CW'(CMD_BITS - 1);
          bus.pad_data_in <= bus.cmd_in[CMD_BITS-1];
          bus.busy <= 1'b1;
          bus.timeout_err <= 1'b0;
          bus.end_err <= 1'b0;
          bus.resp_out <= '0;
        end
        SEND: if (cnt == '0) begin
          state <= exp_r ? WAIT_START : DONE;
          bus.pad_data_in <= 1'b1;
          bus.pad_output_input <= ~exp_r;
          bus.done <= ~exp_r;
          to_cnt <= '0;
        end else begin
          bus.pad_data_in <= cmd_sh[CMD_BITS-1];
          cmd_sh <= cmd_sh << 1;
          cnt <= cnt - 1'b1;
        end
        WAIT_START: if (!bus.pad_data_out) begin
          state <= RECEIVE;
          resp_sh <= {resp_sh[RESP_BITS-3:0], 1'b0};
          cnt <= CW'(RESP_BITS - 1);
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          state <= DONE;
          bus.timeout_err <= 1'b1;
          bus.done <= 1'b1;
          bus.pad_output_input <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
        RECEIVE: begin
          resp_sh <= {resp_sh[RESP_BITS-3:0], bus.pad_data_out};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            bus.resp_out <= {resp_sh, bus.pad_data_out};
            bus.end_err <= ~bus.pad_data_out;
            bus.done <= 1'b1;
            bus.pad_output_input <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
